// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

   // Arbiter FSM states; explicit encoding keeps the state register layout stable.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CORE_ACC = 2'd1,
      GEMM_ACC = 2'd2
   } state_e;

   // Requester identity, used for the round-robin history bit.
   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_GEMM = 1'b1
   } req_e;

   // GEMM engine always performs full-word accesses.
   localparam logic [2:0] FUNC3_WORD = 3'b010;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of core, GEMM and memory-side signals around the data-memory arbiter.
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              core_req;
   logic              core_we;
   logic [2:0]        core_func3;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W-1:0] core_rdata;
   logic              core_stall;

   logic              gemm_req;
   logic              gemm_we;
   logic [ADDR_W-1:0] gemm_addr;
   logic [DATA_W-1:0] gemm_wdata;
   logic              gemm_gnt;
   logic              gemm_rvalid;
   logic [DATA_W-1:0] gemm_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [2:0]        mem_func3;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side.
   modport slave (
      input  core_req, core_we, core_func3, core_addr, core_wdata,
      output core_rdata, core_stall,
      input  gemm_req, gemm_we, gemm_addr, gemm_wdata,
      output gemm_gnt, gemm_rvalid, gemm_rdata,
      output mem_en, mem_we, mem_func3, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment side: requesters and memory.
   modport master (
      output core_req, core_we, core_func3, core_addr, core_wdata,
      input  core_rdata, core_stall,
      output gemm_req, gemm_we, gemm_addr, gemm_wdata,
      input  gemm_gnt, gemm_rvalid, gemm_rdata,
      input  mem_en, mem_we, mem_func3, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data-memory port between
// the core MEM stage and the GEMM load/store engine, one access at a time.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input logic          clk,
   input logic          reset,
   dmem_arbiter_if.slave bus
);

   localparam int unsigned       CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(MEM_LAT);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   req_e                last_q, last_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [2:0]          mem_func3_q, mem_func3_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                gnt_q, gnt_d;

   logic                pick_gemm_c;
   logic                core_done_c;
   logic                gemm_done_c;

   // Completion flags: the cycle the memory returns data for the access in flight.
   assign core_done_c = (state_q == CORE_ACC) && (cnt_q == CNT_DONE);
   assign gemm_done_c = (state_q == GEMM_ACC) && (cnt_q == CNT_DONE);

   // GEMM wins when alone, or on a conflict if the core was granted last.
   assign pick_gemm_c = bus.gemm_req && (!bus.core_req || (last_q == REQ_CORE));

   // State, history, latency counter and registered memory-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         last_q      <= REQ_GEMM;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_func3_q <= 3'b000;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         gnt_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_func3_q <= mem_func3_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         gnt_q       <= gnt_d;
      end
   end

   // Next-state: arbitrate in IDLE, then count out the fixed memory latency.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      mem_en_d    = 1'b0;
      gnt_d       = 1'b0;
      mem_we_d    = mem_we_q;
      mem_func3_d = mem_func3_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         IDLE: begin
            if (bus.core_req || bus.gemm_req) begin
               mem_en_d = 1'b1;
               cnt_d    = '0;
               if (pick_gemm_c) begin
                  state_d     = GEMM_ACC;
                  last_d      = REQ_GEMM;
                  gnt_d       = 1'b1;
                  mem_we_d    = bus.gemm_we;
                  mem_func3_d = FUNC3_WORD;
                  mem_addr_d  = bus.gemm_addr;
                  mem_wdata_d = bus.gemm_wdata;
               end else begin
                  state_d     = CORE_ACC;
                  last_d      = REQ_CORE;
                  mem_we_d    = bus.core_we;
                  mem_func3_d = bus.core_func3;
                  mem_addr_d  = bus.core_addr;
                  mem_wdata_d = bus.core_wdata;
               end
            end
         end
         CORE_ACC, GEMM_ACC: begin
            if (cnt_q == CNT_DONE) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output drive; read data is passed through only in its completion cycle.
   assign bus.mem_en      = mem_en_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_func3   = mem_func3_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wdata   = mem_wdata_q;
   assign bus.gemm_gnt    = gnt_q;
   assign bus.gemm_rvalid = gemm_done_c;
   assign bus.gemm_rdata  = gemm_done_c ? bus.mem_rdata : '0;
   assign bus.core_rdata  = core_done_c ? bus.mem_rdata : '0;
   assign bus.core_stall  = bus.core_req && !core_done_c;

endmodule
